// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the 2:1 mux sequencer.
// State encoding plus the clamp-to-1 rule applied to dwell lengths.
package mux_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DWELL_A  = 3'd1,
    BLANK_AB = 3'd2,
    DWELL_B  = 3'd3,
    BLANK_BA = 3'd4
  } state_t;

  // Widest counter the clamp helper supports; callers cast to their own width.
  localparam int CLAMP_WIDTH = 64;

  function automatic logic [CLAMP_WIDTH-1:0] clamp_to_one(input logic [CLAMP_WIDTH-1:0] value);
    clamp_to_one = (value == '0) ? CLAMP_WIDTH'(1) : value;
  endfunction

endpackage

// File: rtl/mux_2_sequencer.sv
// Drives a 2:1 mux select: A for dwell_a cycles, B for dwell_b cycles, with optional
// blanking after each switch; config is shadowed and applied only at period starts.
module mux_2_sequencer
  import mux_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] dwell_a_i,
  input  logic [CNT_WIDTH-1:0] dwell_b_i,
  input  logic [CNT_WIDTH-1:0] blank_i,
  input  logic                 load_i,
  output logic                 sel_o,
  output logic                 blank_o,
  output logic                 period_o,
  output logic                 busy_o
);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 sel_reg, sel_next;
  logic                 blank_reg, blank_next;
  logic                 period_reg, period_next;
  logic                 busy_reg, busy_next;

  logic [CNT_WIDTH-1:0] act_dwell_a_reg, act_dwell_b_reg, act_blank_reg;
  logic [CNT_WIDTH-1:0] pend_dwell_a_reg, pend_dwell_b_reg, pend_blank_reg;
  logic                 pend_valid_reg;

  logic [CNT_WIDTH-1:0] eff_dwell_a_raw, eff_dwell_b_raw, eff_blank;
  logic [CNT_WIDTH-1:0] eff_dwell_a, eff_dwell_b;
  logic                 enter_a;
  logic                 apply;

  // Config that would become active if this edge enters DWELL_A:
  // a same-cycle load beats pending, pending beats the current active set.
  always_comb begin
    eff_dwell_a_raw = act_dwell_a_reg;
    eff_dwell_b_raw = act_dwell_b_reg;
    eff_blank       = act_blank_reg;
    if (load_i) begin
      eff_dwell_a_raw = dwell_a_i;
      eff_dwell_b_raw = dwell_b_i;
      eff_blank       = blank_i;
    end else if (pend_valid_reg) begin
      eff_dwell_a_raw = pend_dwell_a_reg;
      eff_dwell_b_raw = pend_dwell_b_reg;
      eff_blank       = pend_blank_reg;
    end
    eff_dwell_a = CNT_WIDTH'(clamp_to_one(CLAMP_WIDTH'(eff_dwell_a_raw)));
    eff_dwell_b = CNT_WIDTH'(clamp_to_one(CLAMP_WIDTH'(eff_dwell_b_raw)));
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sel_next    = sel_reg;
    blank_next  = blank_reg;
    period_next = 1'b0;
    enter_a     = 1'b0;
    apply       = 1'b0;

    if (!enable_i) begin
      state_next = IDLE;
      cnt_next   = '0;
      sel_next   = 1'b0;
      blank_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: enter_a = 1'b1;

        DWELL_A: begin
          if (cnt_reg == '0) begin
            sel_next = 1'b0;
            if (act_blank_reg != '0) begin
              state_next = BLANK_AB;
              cnt_next   = act_blank_reg - 1'b1;
              blank_next = 1'b1;
            end else begin
              state_next = DWELL_B;
              cnt_next   = act_dwell_b_reg - 1'b1;
              blank_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        BLANK_AB: begin
          if (cnt_reg == '0) begin
            state_next = DWELL_B;
            cnt_next   = act_dwell_b_reg - 1'b1;
            sel_next   = 1'b0;
            blank_next = 1'b0;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        DWELL_B: begin
          if (cnt_reg == '0) begin
            if (act_blank_reg != '0) begin
              state_next = BLANK_BA;
              cnt_next   = act_blank_reg - 1'b1;
              sel_next   = 1'b1;
              blank_next = 1'b1;
            end else begin
              enter_a = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        BLANK_BA: begin
          if (cnt_reg == '0) begin
            enter_a = 1'b1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          sel_next   = 1'b0;
          blank_next = 1'b0;
        end
      endcase

      // Every entry into DWELL_A starts a period with freshly applied config.
      if (enter_a) begin
        state_next  = DWELL_A;
        cnt_next    = eff_dwell_a - 1'b1;
        sel_next    = 1'b1;
        blank_next  = 1'b0;
        period_next = 1'b1;
        apply       = 1'b1;
      end
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sel_reg    <= 1'b0;
      blank_reg  <= 1'b0;
      period_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      blank_reg  <= blank_next;
      period_reg <= period_next;
      busy_reg   <= busy_next;
    end
  end

  // A load coinciding with an apply is consumed immediately, so pending stays empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_dwell_a_reg  <= CNT_WIDTH'(1);
      act_dwell_b_reg  <= CNT_WIDTH'(1);
      act_blank_reg    <= '0;
      pend_dwell_a_reg <= '0;
      pend_dwell_b_reg <= '0;
      pend_blank_reg   <= '0;
      pend_valid_reg   <= 1'b0;
    end else begin
      if (load_i) begin
        pend_dwell_a_reg <= dwell_a_i;
        pend_dwell_b_reg <= dwell_b_i;
        pend_blank_reg   <= blank_i;
      end
      if (apply) begin
        act_dwell_a_reg <= eff_dwell_a;
        act_dwell_b_reg <= eff_dwell_b;
        act_blank_reg   <= eff_blank;
        pend_valid_reg  <= 1'b0;
      end else if (load_i) begin
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign sel_o    = sel_reg;
  assign blank_o  = blank_reg;
  assign period_o = period_reg;
  assign busy_o   = busy_reg;

endmodule

// File: tb/tb_mux_2_sequencer.sv
// Scoreboard bench for mux_2_sequencer: each period's expected output pattern is
// queued when stimulus is applied and popped one entry per clock.
module tb_mux_2_sequencer;

  typedef struct packed {
    logic sel;
    logic blank;
    logic period;
    logic busy;
  } exp_t;

  localparam exp_t IDLE_EXP = '{sel: 1'b0, blank: 1'b0, period: 1'b0, busy: 1'b0};

  logic        clk;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] dwell_a_i, dwell_b_i, blank_i;
  logic        load_i;
  logic        sel_o, blank_o, period_o, busy_o;
  logic [3:0]  obs;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  mux_2_sequencer #(.CNT_WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .dwell_a_i(dwell_a_i),
    .dwell_b_i(dwell_b_i),
    .blank_i  (blank_i),
    .load_i   (load_i),
    .sel_o    (sel_o),
    .blank_o  (blank_o),
    .period_o (period_o),
    .busy_o   (busy_o)
  );

  assign obs = {sel_o, blank_o, period_o, busy_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // One full period as seen on the outputs, built from the timing rules
  // (A dwell, blank, B dwell, blank) rather than from a state machine.
  function automatic void push_period(input int a, input int b, input int bl);
    int ca = (a == 0) ? 1 : a;
    int cb = (b == 0) ? 1 : b;
    for (int i = 0; i < ca; i++) sb.push_back('{sel: 1'b1, blank: 1'b0, period: (i == 0), busy: 1'b1});
    for (int i = 0; i < bl; i++) sb.push_back('{sel: 1'b0, blank: 1'b1, period: 1'b0, busy: 1'b1});
    for (int i = 0; i < cb; i++) sb.push_back('{sel: 1'b0, blank: 1'b0, period: 1'b0, busy: 1'b1});
    for (int i = 0; i < bl; i++) sb.push_back('{sel: 1'b1, blank: 1'b1, period: 1'b0, busy: 1'b1});
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; load_i = 1'b0;
    dwell_a_i = 32'd0; dwell_b_i = 32'd0; blank_i = 32'd0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset: got %b want 0000", obs);
      end
    end
    rst_i = 1'b0;
    sb.push_back(IDLE_EXP);
    sb.push_back(IDLE_EXP);
    repeat (2) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++; e = sb.pop_front();
      if (obs !== e) begin
        miscompares++;
        $display("FAIL idle_after_reset: got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_basic();
    enable_i = 1'b0; load_i = 1'b1;
    dwell_a_i = 32'd3; dwell_b_i = 32'd2; blank_i = 32'd0;
    sb.push_back(IDLE_EXP);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL basic_3_2_0: cycle %0d got %b want scoreboard entry", i, obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          miscompares++;
          $display("FAIL basic_3_2_0: cycle %0d got %b want %b", i, obs, e);
        end
      end
      if (i == 0) begin
        load_i = 1'b0; enable_i = 1'b1;
        push_period(3, 2, 0); push_period(3, 2, 0); push_period(3, 2, 0);
      end
    end
  endtask

  task automatic test_blank();
    enable_i = 1'b0; load_i = 1'b1;
    dwell_a_i = 32'd2; dwell_b_i = 32'd2; blank_i = 32'd1;
    sb.push_back(IDLE_EXP);
    for (int i = 0; i < 19; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL blank_2_2_1: cycle %0d got %b want scoreboard entry", i, obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          miscompares++;
          $display("FAIL blank_2_2_1: cycle %0d got %b want %b", i, obs, e);
        end
      end
      if (i == 0) begin
        load_i = 1'b0; enable_i = 1'b1;
        push_period(2, 2, 1); push_period(2, 2, 1); push_period(2, 2, 1);
      end
    end
  endtask

  task automatic test_reload();
    enable_i = 1'b0; load_i = 1'b1;
    dwell_a_i = 32'd3; dwell_b_i = 32'd2; blank_i = 32'd0;
    sb.push_back(IDLE_EXP);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL reload_mid_a: cycle %0d got %b want scoreboard entry", i, obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          miscompares++;
          $display("FAIL reload_mid_a: cycle %0d got %b want %b", i, obs, e);
        end
      end
      load_i = 1'b0;
      if (i == 0) begin
        enable_i = 1'b1;
        push_period(3, 2, 0); push_period(1, 1, 0); push_period(1, 1, 0);
      end
      if (i == 1) begin
        dwell_a_i = 32'd1; dwell_b_i = 32'd1; blank_i = 32'd0; load_i = 1'b1;
      end
    end
  endtask

  task automatic test_zero_dwell();
    // Load coincides with the IDLE -> DWELL_A edge, so the new values apply at once.
    enable_i = 1'b0; load_i = 1'b0;
    sb.push_back(IDLE_EXP);
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL zero_dwell: cycle %0d got %b want scoreboard entry", i, obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          miscompares++;
          $display("FAIL zero_dwell: cycle %0d got %b want %b", i, obs, e);
        end
      end
      load_i = 1'b0;
      if (i == 0) begin
        dwell_a_i = 32'd0; dwell_b_i = 32'd0; blank_i = 32'd0;
        load_i = 1'b1; enable_i = 1'b1;
        push_period(0, 0, 0); push_period(0, 0, 0); push_period(0, 0, 0); push_period(0, 0, 0);
      end
    end
  endtask

  task automatic test_drop_in_blank();
    enable_i = 1'b0; load_i = 1'b1;
    dwell_a_i = 32'd2; dwell_b_i = 32'd2; blank_i = 32'd1;
    sb.push_back(IDLE_EXP);
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL drop_in_blank: cycle %0d got %b want scoreboard entry", i, obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          miscompares++;
          $display("FAIL drop_in_blank: cycle %0d got %b want %b", i, obs, e);
        end
      end
      load_i = 1'b0;
      if (i == 0) begin
        enable_i = 1'b1;
        sb.push_back('{sel: 1'b1, blank: 1'b0, period: 1'b1, busy: 1'b1});
        sb.push_back('{sel: 1'b1, blank: 1'b0, period: 1'b0, busy: 1'b1});
        sb.push_back('{sel: 1'b0, blank: 1'b1, period: 1'b0, busy: 1'b1});
      end
      if (i == 3) begin
        enable_i = 1'b0;
        sb.push_back(IDLE_EXP);
      end
      if (i == 4) begin
        enable_i = 1'b1;
        push_period(2, 2, 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    enable_i = 1'b0; load_i = 1'b1;
    dwell_a_i = 32'd3; dwell_b_i = 32'd2; blank_i = 32'd0;
    sb.push_back(IDLE_EXP);
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      e = sb.pop_front();
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_pre: cycle %0d got %b want %b", i, obs, e);
      end
      load_i = 1'b0;
      if (i == 0) begin
        enable_i = 1'b1;
        sb.push_back('{sel: 1'b1, blank: 1'b0, period: 1'b1, busy: 1'b1});
        sb.push_back('{sel: 1'b1, blank: 1'b0, period: 1'b0, busy: 1'b1});
        sb.push_back('{sel: 1'b1, blank: 1'b0, period: 1'b0, busy: 1'b1});
        sb.push_back('{sel: 1'b0, blank: 1'b0, period: 1'b0, busy: 1'b1});
      end
    end
    // Now in DWELL_B; assert reset between edges and expect an immediate clear.
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %b want 0000", obs);
    end
    @(negedge clk);
    rst_i = 1'b0;
    // Active config is back to 1/1/0 and pending was cleared.
    push_period(1, 1, 0); push_period(1, 1, 0); push_period(1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      @(posedge clk); @(negedge clk);
      vectors++;
      e = sb.pop_front();
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_restart: cycle %0d got %b want %b", i, obs, e);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_blank();
    test_reload();
    test_zero_dwell();
    test_drop_in_blank();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
